// File: rtl/mux_canales_rr.sv
// N-channel registered multiplexer with valid/ready handshake, manual or round-robin selection.
// Optional build macro MUX_ZERO_IDLE_EN: zero Salida/Canal whenever the output register is empty.
module mux_canales_rr #(
  parameter int WIDTH   = 21,
  parameter int CANALES = 3,
  parameter int SEL_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CANALES*WIDTH-1:0]   Entrada,
  input  logic [CANALES-1:0]         Valido_in,
  output logic [CANALES-1:0]         Ack_in,
  input  logic                       Modo,
  input  logic [SEL_W-1:0]           Select,
  output logic [WIDTH-1:0]           Salida,
  output logic [SEL_W-1:0]           Canal,
  output logic                       Valido_out,
  input  logic                       Listo_out
);

  typedef enum logic {
    VACIO = 1'b0,
    LLENO = 1'b1
  } estado_t;

  estado_t          estado_q;
  logic [WIDTH-1:0] salida_q;
  logic [SEL_W-1:0] canal_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] grantIdx;
  logic             grant;
  logic             carga;
  logic [WIDTH-1:0] words [CANALES];

  for (genvar k = 0; k < CANALES; k++) begin : g_words
    assign words[k] = Entrada[k*WIDTH +: WIDTH];
  end

  // An empty register, or one being drained this cycle, can accept a new word.
  assign carga = (estado_q == VACIO) | Listo_out;

  always_comb begin
    int idx;
    grant    = 1'b0;
    grantIdx = '0;
    idx      = 0;
    if (!Modo) begin
      grantIdx = (32'(Select) >= 32'(CANALES)) ? '0 : Select;
      grant    = Valido_in[grantIdx];
    end else begin
      // Walk offsets from farthest to nearest so the channel closest to ptr wins.
      for (int i = CANALES - 1; i >= 0; i--) begin
        idx = int'(32'(ptr_q)) + i;
        if (idx >= CANALES) begin
          idx = idx - CANALES;
        end
        if (Valido_in[idx]) begin
          grant    = 1'b1;
          grantIdx = SEL_W'(idx);
        end
      end
    end
  end

  assign ptr_d  = (grantIdx == SEL_W'(CANALES - 1)) ? '0 : grantIdx + 1'b1;
  assign Ack_in = (!reset && carga && grant) ? (CANALES'(1) << grantIdx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= VACIO;
      salida_q <= '0;
      canal_q  <= '0;
      ptr_q    <= '0;
    end else if (carga) begin
      if (grant) begin
        estado_q <= LLENO;
        salida_q <= words[grantIdx];
        canal_q  <= grantIdx;
        if (Modo) begin
          ptr_q <= ptr_d;
        end
      end else begin
        estado_q <= VACIO;
`ifdef MUX_ZERO_IDLE_EN
        salida_q <= '0;
        canal_q  <= '0;
`endif
      end
    end
  end

  assign Salida     = salida_q;
  assign Canal      = canal_q;
  assign Valido_out = (estado_q == LLENO);

endmodule

// File: tb/tb_mux_canales_rr.sv
// Bench for mux_canales_rr: directed scenarios then randomized traffic against a transaction-level model.
module tb_mux_canales_rr;

  localparam int WIDTH   = 21;
  localparam int CANALES = 3;
  localparam int SEL_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [CANALES*WIDTH-1:0] Entrada;
  logic [CANALES-1:0]       Valido_in;
  logic [CANALES-1:0]       Ack_in;
  logic                     Modo;
  logic [SEL_W-1:0]         Select;
  logic [WIDTH-1:0]         Salida;
  logic [SEL_W-1:0]         Canal;
  logic                     Valido_out;
  logic                     Listo_out;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0]   wordIn [CANALES];
  logic [CANALES-1:0] validIn;

  // Model of what the output register should hold and where the RR search starts.
  bit                 mValid;
  logic [WIDTH-1:0]   mData;
  int                 mChan;
  int                 mPtr;
  logic [CANALES-1:0] expAck;

  mux_canales_rr #(.WIDTH(WIDTH), .CANALES(CANALES), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Entrada    (Entrada),
    .Valido_in  (Valido_in),
    .Ack_in     (Ack_in),
    .Modo       (Modo),
    .Select     (Select),
    .Salida     (Salida),
    .Canal      (Canal),
    .Valido_out (Valido_out),
    .Listo_out  (Listo_out)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs();
    for (int k = 0; k < CANALES; k++) begin
      Entrada[k*WIDTH +: WIDTH] = wordIn[k];
    end
    Valido_in = validIn;
  endtask

  task automatic randWords();
    for (int k = 0; k < CANALES; k++) begin
      wordIn[k] = WIDTH'($urandom);
    end
  endtask

  // Winner among requesting channels: fixed channel in manual mode, first from ptr onward in RR.
  function automatic int pickGrant();
    int s;
    if (!Modo) begin
      s = (int'(Select) < CANALES) ? int'(Select) : 0;
      return validIn[s] ? s : -1;
    end
    for (int k = 0; k < CANALES; k++) begin
      s = (mPtr + k) % CANALES;
      if (validIn[s]) return s;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag);
    int g;
    bit load;
    g      = pickGrant();
    load   = !mValid || Listo_out;
    expAck = (!reset && load && g >= 0) ? (CANALES'(1) << g) : '0;
    checkEq({tag, ".ack"}, 32'(Ack_in), 32'(expAck));
    checkEq({tag, ".vld"}, 32'(Valido_out), 32'(mValid));
    checkEq({tag, ".dat"}, 32'(Salida), 32'(mData));
    checkEq({tag, ".ch"},  32'(Canal), 32'(mChan));
    if (reset) begin
      mValid = 1'b0;
      mData  = '0;
      mChan  = 0;
      mPtr   = 0;
    end else if (load) begin
      if (g >= 0) begin
        mValid = 1'b1;
        mData  = wordIn[g];
        mChan  = g;
        if (Modo) mPtr = (g + 1) % CANALES;
      end else begin
        mValid = 1'b0;
`ifdef MUX_ZERO_IDLE_EN
        mData  = '0;
        mChan  = 0;
`endif
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input int n);
    repeat (n) begin
      driveInputs();
      @(negedge clk);
      checkOutput(tag);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    Modo      = 1'b0;
    Select    = '0;
    Listo_out = 1'b1;
    validIn   = 3'b111;
    randWords();
    driveInputs();
    mValid = 1'b0;
    mData  = '0;
    mChan  = 0;
    mPtr   = 0;
    @(posedge clk);
    #1;

    // Reset with every input active.
    applyStimulus("reset", 1);
    reset = 1'b0;

    // Manual mode, in range then out of range.
    Select = 2'd2;
    for (int i = 0; i < 4; i++) begin
      randWords();
      applyStimulus("manual2", 1);
      checkEq("manual2.canal", 32'(Canal), 32'd2);
    end
    Select = 2'd3;
    for (int i = 0; i < 3; i++) begin
      randWords();
      applyStimulus("manualOor", 1);
      checkEq("manualOor.canal", 32'(Canal), 32'd0);
    end

    // Round-robin fairness with all channels requesting.
    Modo = 1'b1;
    for (int i = 0; i < 6; i++) begin
      randWords();
      applyStimulus("rrFair", 1);
      checkEq("rrFair.seq", 32'(Canal), 32'(i % 3));
    end

    // Move ptr to 2, then skip the idle channel and wrap.
    validIn = 3'b010;
    applyStimulus("rrSetPtr", 1);
    validIn = 3'b011;
    for (int i = 0; i < 3; i++) begin
      randWords();
      applyStimulus("rrWrap", 1);
      checkEq("rrWrap.seq", 32'(Canal), 32'((i == 1) ? 1 : 0));
    end

    // Backpressure, then release for simultaneous drain and load.
    validIn   = 3'b111;
    Listo_out = 1'b0;
    applyStimulus("backpressure", 4);
    Listo_out = 1'b1;
    applyStimulus("bpRelease", 2);

    // Idle drain, then reset while the register is full.
    validIn = 3'b000;
    applyStimulus("idle", 3);
    checkEq("idle.vld", 32'(Valido_out), 32'd0);
    validIn   = 3'b101;
    Listo_out = 1'b0;
    applyStimulus("fill", 1);
    reset = 1'b1;
    applyStimulus("rstFull", 1);
    reset = 1'b0;
    applyStimulus("afterRst", 1);

    // Randomized traffic; sources hold their word until acknowledged.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) Modo = ~Modo;
      Select    = SEL_W'($urandom_range(0, 3));
      Listo_out = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 63) == 0);
      applyStimulus("random", 1);
      for (int k = 0; k < CANALES; k++) begin
        if (expAck[k] || !validIn[k]) begin
          validIn[k] = $urandom_range(0, 1) == 1;
          wordIn[k]  = WIDTH'($urandom);
        end
      end
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
